add_4: RTL and testbench



---
 rtl/add_4.sv | 98 +++++++++
 tb/tb_add_4.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/add_4.sv
// Four-bit carry-lookahead adder slice with registered sum, carry-out and group P/G.
// Define ADD4_INPUT_REG_EN to add a registered input stage (latency 2 instead of 1).
`timescale 1ns/1ps

module add_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       C_out,
  output logic       P_out,
  output logic       G_out
);

  logic [3:0] opA;
  logic [3:0] opB;
  logic       opCin;

`ifdef ADD4_INPUT_REG_EN
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       cin_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= 4'h0;
      b_q   <= 4'h0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= A;
      b_q   <= B;
      cin_q <= C_in;
    end
  end

  assign opA   = a_q;
  assign opB   = b_q;
  assign opCin = cin_q;
`else
  assign opA   = A;
  assign opB   = B;
  assign opCin = C_in;
`endif

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;
  logic [3:0] s_d;
  logic       cOut_d;
  logic       pOut_d;
  logic       gOut_d;

  assign p = opA ^ opB;
  assign g = opA & opB;

  // Every carry is a flat sum of products so no carry depends on another carry.
  assign c[0] = opCin;
  assign c[1] = g[0] | (p[0] & opCin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & opCin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & opCin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & opCin);

  assign s_d    = p ^ c[3:0];
  assign cOut_d = c[4];
  assign pOut_d = &p;
  assign gOut_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);

  logic [3:0] s_q;
  logic       cOut_q;
  logic       pOut_q;
  logic       gOut_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 4'h0;
      cOut_q <= 1'b0;
      pOut_q <= 1'b0;
      gOut_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cOut_q <= cOut_d;
      pOut_q <= pOut_d;
      gOut_q <= gOut_d;
    end
  end

  assign S     = s_q;
  assign C_out = cOut_q;
  assign P_out = pOut_q;
  assign G_out = gOut_q;

endmodule

// File: tb/tb_add_4.sv
// Scoreboard bench for add_4: stimulus pushes expected results, a monitor pops and compares.
// Honours ADD4_INPUT_REG_EN to pick the expected latency.
`timescale 1ns/1ps

module tb_add_4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] A = 4'h0;
  logic [3:0] B = 4'h0;
  logic       C_in = 1'b0;
  logic [3:0] S;
  logic       C_out;
  logic       P_out;
  logic       G_out;

`ifdef ADD4_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    bit         valid;
    logic [3:0] s;
    logic       c;
    logic       p;
    logic       g;
    logic       cin;
  } exp_t;

  exp_t expQ[$];
  exp_t inflight[$];
  int   tests = 0;
  int   fails = 0;

  add_4 dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .S     (S),
    .C_out (C_out),
    .P_out (P_out),
    .G_out (G_out)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition; P means A+B is exactly 15, G means A+B overflows alone.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic ci);
    exp_t m;
    int total;
    int ab;
    ab      = int'(a) + int'(b);
    total   = ab + int'(ci);
    m.valid = 1'b1;
    m.s     = 4'(total % 16);
    m.c     = (total >= 16);
    m.p     = (ab == 15);
    m.g     = (ab >= 16);
    m.cin   = ci;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk);
    A    = a;
    B    = b;
    C_in = ci;
    expQ.push_back(model(a, b, ci));
  endtask

  task automatic applyDirected(input logic [3:0] a, input logic [3:0] b, input logic ci,
                               input logic [3:0] s, input logic c, input logic p, input logic g);
    exp_t e;
    @(negedge clk);
    A    = a;
    B    = b;
    C_in = ci;
    e.valid = 1'b1;
    e.s     = s;
    e.c     = c;
    e.p     = p;
    e.g     = g;
    e.cin   = ci;
    expQ.push_back(e);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_S"}, 32'(S), 32'h0);
    checkOutput({name, "_C_out"}, 32'(C_out), 32'h0);
    checkOutput({name, "_P_out"}, 32'(P_out), 32'h0);
    checkOutput({name, "_G_out"}, 32'(G_out), 32'h0);
  endtask

  // Monitor: each capture edge moves one queued expectation into the latency pipe.
  initial begin
    exp_t item;
    exp_t idle;
    idle.valid = 1'b0;
    idle.s = 4'h0; idle.c = 1'b0; idle.p = 1'b0; idle.g = 1'b0; idle.cin = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        inflight.delete();
      end else begin
        if (expQ.size() > 0) inflight.push_back(expQ.pop_front());
        else inflight.push_back(idle);
        #1;
        if (inflight.size() >= LAT) begin
          item = inflight.pop_front();
          if (item.valid) begin
            checkOutput("sum", 32'(S), 32'(item.s));
            checkOutput("carry", 32'(C_out), 32'(item.c));
            checkOutput("group_p", 32'(P_out), 32'(item.p));
            checkOutput("group_g", 32'(G_out), 32'(item.g));
            checkOutput("invariant", 32'(C_out), 32'(G_out | (P_out & item.cin)));
          end
        end
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    #1 checkAllZero("reset_initial");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyDirected(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    applyDirected(4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    applyDirected(4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0);
    applyDirected(4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++)
          applyStimulus(4'(a), 4'(b), 1'(ci));

    for (int i = 0; i < 10000; i++)
      applyStimulus(4'($urandom), 4'($urandom), 1'($urandom % 2));

    // Mid-run reset: get nonzero outputs on screen, then reset between edges.
    applyStimulus(4'hE, 4'hF, 1'b1);
    repeat (LAT) @(posedge clk);
    #2;
    checkOutput("pre_reset_sum_nonzero", 32'(S != 4'h0), 32'h1);
    rst = 1'b1;
    #1 checkAllZero("reset_async");
    repeat (3) begin
      @(negedge clk);
      checkAllZero("reset_held");
    end
    rst = 1'b0;
    #1 checkAllZero("reset_released");

    applyDirected(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++)
      applyStimulus(4'($urandom), 4'($urandom), 1'($urandom % 2));

    repeat (LAT + 3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
